uc_stack: RTL and testbench

//  Single-cycle control unit with subroutine support and a sticky run/halt/error FSM.

---
 rtl/uc_stack.sv | 155 +++++++++++++++
 tb/tb_uc_stack.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/uc_stack.sv
// Single-cycle control unit: decodes opcode[3:0] into datapath selects, keeps a
// return-address stack for CALL/RET, and holds a sticky RUN/HALT/ERR state.
module uc_stack #(
    parameter int unsigned OPW   = 6,
    parameter int unsigned ALUW  = 3,
    parameter int unsigned PCW   = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            z,
    input  logic [OPW-1:0]  opcode,
    input  logic [PCW-1:0]  pc_next,
    output logic            pc_en,
    output logic            s_inc,
    output logic            s_inc2,
    output logic            s_ret,
    output logic            s_inm,
    output logic            we3,
    output logic [ALUW-1:0] op,
    output logic [PCW-1:0]  ret_addr,
    output logic            fin,
    output logic            err
);

    localparam int unsigned SPW = $clog2(DEPTH + 1);
    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic [PCW-1:0] stack_q [DEPTH];
    logic [PCW-1:0] stack_d [DEPTH];
    logic           push;

    // Upper opcode bits are intentionally ignored by the decoder
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^opcode;

    assign ret_addr = (sp_q == '0) ? '0 : stack_q[AW'(sp_q - SPW'(1))];

    // Decode, stack-pointer and next-state logic
    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        push    = 1'b0;
        pc_en   = 1'b0;
        s_inc   = 1'b0;
        s_inc2  = 1'b0;
        s_ret   = 1'b0;
        s_inm   = 1'b0;
        we3     = 1'b0;
        op      = '0;
        fin     = 1'b0;
        err     = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (!opcode[3]) begin
                    we3   = 1'b1;
                    op    = ALUW'(opcode[ALUW-1:0]);
                    s_inc = 1'b1;
                    pc_en = 1'b1;
                end else begin
                    case (opcode[2:0])
                        3'b000: begin
                            we3   = 1'b1;
                            s_inm = 1'b1;
                            s_inc = 1'b1;
                            pc_en = 1'b1;
                        end
                        3'b001: pc_en = 1'b1;
                        3'b010: begin
                            s_inc = ~z;
                            pc_en = 1'b1;
                        end
                        3'b011: begin
                            s_inc = z;
                            pc_en = 1'b1;
                        end
                        3'b100: begin
                            s_inc  = 1'b1;
                            s_inc2 = 1'b1;
                            pc_en  = 1'b1;
                        end
                        3'b101: begin
                            if (sp_q == SPW'(DEPTH)) begin
                                state_d = ST_ERR;
                            end else begin
                                pc_en = 1'b1;
                                push  = 1'b1;
                                sp_d  = sp_q + SPW'(1);
                            end
                        end
                        3'b110: begin
                            if (sp_q == '0) begin
                                state_d = ST_ERR;
                            end else begin
                                s_ret = 1'b1;
                                pc_en = 1'b1;
                                sp_d  = sp_q - SPW'(1);
                            end
                        end
                        default: state_d = ST_HALT;
                    endcase
                end
            end
            ST_HALT: fin = 1'b1;
            ST_ERR:  err = 1'b1;
            default: state_d = ST_ERR;
        endcase

        // Reset dominates: quiet outputs and no stack side effects this edge
        if (reset) begin
            push   = 1'b0;
            pc_en  = 1'b0;
            s_inc  = 1'b0;
            s_inc2 = 1'b0;
            s_ret  = 1'b0;
            s_inm  = 1'b0;
            we3    = 1'b0;
            op     = '0;
            fin    = 1'b0;
            err    = 1'b0;
        end
    end

    always_comb begin
        stack_d = stack_q;
        if (push) begin
            stack_d[AW'(sp_q)] = pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            sp_q    <= '0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
        end
    end

    // Stack storage is deliberately not cleared by reset
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

endmodule

// File: tb/tb_uc_stack.sv
// Self-checking bench for uc_stack: directed scenarios plus random opcodes,
// compared each cycle against a queue-based reference model.
module tb_uc_stack;

    localparam int unsigned OPW   = 6;
    localparam int unsigned ALUW  = 3;
    localparam int unsigned PCW   = 10;
    localparam int unsigned DEPTH = 4;

    localparam int M_RUN  = 0;
    localparam int M_HALT = 1;
    localparam int M_ERR  = 2;

    logic            clk;
    logic            reset;
    logic            z;
    logic [OPW-1:0]  opcode;
    logic [PCW-1:0]  pc_next;
    logic            pc_en, s_inc, s_inc2, s_ret, s_inm, we3, fin, err;
    logic [ALUW-1:0] op;
    logic [PCW-1:0]  ret_addr;

    int errors = 0;
    int checks = 0;

    int             m_state = M_RUN;
    logic [PCW-1:0] m_stack [$];

    uc_stack #(.OPW(OPW), .ALUW(ALUW), .PCW(PCW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .z(z), .opcode(opcode), .pc_next(pc_next),
        .pc_en(pc_en), .s_inc(s_inc), .s_inc2(s_inc2), .s_ret(s_ret),
        .s_inm(s_inm), .we3(we3), .op(op), .ret_addr(ret_addr),
        .fin(fin), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One instruction cycle: drive, check mid-cycle, advance model at the edge
    task automatic step(input logic [5:0] opc, input logic zz, input logic [PCW-1:0] pcn,
                        input logic rst);
        logic [3:0]      code;
        logic            e_pc_en, e_s_inc, e_s_inc2, e_s_ret, e_s_inm, e_we3, e_fin, e_err;
        logic [ALUW-1:0] e_op;
        logic [PCW-1:0]  e_ret;
        opcode  = opc;
        z       = zz;
        pc_next = pcn;
        reset   = rst;
        code    = opc[3:0];
        {e_pc_en, e_s_inc, e_s_inc2, e_s_ret, e_s_inm, e_we3, e_fin, e_err} = '0;
        e_op  = '0;
        e_ret = (m_stack.size() == 0) ? '0 : m_stack[m_stack.size() - 1];
        if (!rst) begin
            if (m_state == M_HALT) e_fin = 1'b1;
            else if (m_state == M_ERR) e_err = 1'b1;
            else begin
                case (code)
                    4'd8:  begin e_we3 = 1; e_s_inm = 1; e_s_inc = 1; e_pc_en = 1; end
                    4'd9:  e_pc_en = 1;
                    4'd10: begin e_s_inc = ~zz; e_pc_en = 1; end
                    4'd11: begin e_s_inc = zz;  e_pc_en = 1; end
                    4'd12: begin e_s_inc = 1; e_s_inc2 = 1; e_pc_en = 1; end
                    4'd13: e_pc_en = (m_stack.size() < DEPTH);
                    4'd14: begin
                        e_pc_en = (m_stack.size() > 0);
                        e_s_ret = (m_stack.size() > 0);
                    end
                    4'd15: ;
                    default: begin
                        e_we3 = 1; e_op = code[2:0]; e_s_inc = 1; e_pc_en = 1;
                    end
                endcase
            end
        end
        @(negedge clk);
        check_eq("ctrl", 32'({pc_en, s_inc, s_inc2, s_ret, s_inm, we3, op}),
                 32'({e_pc_en, e_s_inc, e_s_inc2, e_s_ret, e_s_inm, e_we3, e_op}));
        check_eq("fin", 32'(fin), 32'(e_fin));
        check_eq("err", 32'(err), 32'(e_err));
        if (!rst) check_eq("ret_addr", 32'(ret_addr), 32'(e_ret));
        @(posedge clk);
        if (rst) begin
            m_state = M_RUN;
            m_stack.delete();
        end else if (m_state == M_RUN) begin
            if (code == 4'd13) begin
                if (m_stack.size() == DEPTH) m_state = M_ERR;
                else m_stack.push_back(pcn);
            end else if (code == 4'd14) begin
                if (m_stack.size() == 0) m_state = M_ERR;
                else void'(m_stack.pop_back());
            end else if (code == 4'd15) begin
                m_state = M_HALT;
            end
        end
        #1;
    endtask

    initial begin
        reset = 1'b1; z = 1'b0; opcode = '0; pc_next = '0;
        step(6'h00, 0, 10'h0, 1);
        step(6'h0D, 0, 10'h3FF, 1);

        // ALU decode and conditional jumps
        step(6'b000101, 0, 10'h001, 0);
        step(6'h08, 0, 10'h002, 0);
        step(6'h0A, 1, 10'h003, 0);
        step(6'h0A, 0, 10'h004, 0);
        step(6'h0B, 1, 10'h005, 0);
        step(6'h0B, 0, 10'h006, 0);
        step(6'h0C, 0, 10'h007, 0);
        step(6'h09, 1, 10'h008, 0);

        // Nested CALL/RET
        step(6'h0D, 0, 10'h012, 0);
        step(6'h0D, 0, 10'h034, 0);
        step(6'h0E, 0, 10'h000, 0);
        step(6'h0E, 0, 10'h000, 0);
        step(6'h00, 0, 10'h000, 0);

        // Overflow on fifth CALL, then sticky ERR
        for (int i = 0; i < 5; i++) step(6'h0D, 0, PCW'(10'h100 + i), 0);
        step(6'h01, 0, 10'h0, 0);
        step(6'h0E, 1, 10'h0, 0);
        step(6'h00, 0, 10'h0, 1);

        // Underflow, then reset recovery
        step(6'h0E, 0, 10'h0, 0);
        step(6'h03, 0, 10'h0, 0);
        step(6'h00, 0, 10'h0, 1);
        step(6'h02, 0, 10'h0, 0);

        // HALT is sticky; reset with CALL on opcode must not push
        step(6'h0F, 0, 10'h0, 0);
        step(6'h01, 0, 10'h0, 0);
        step(6'h06, 1, 10'h0, 0);
        step(6'h0D, 0, 10'h2AA, 1);
        step(6'h0E, 0, 10'h0, 0);
        step(6'h00, 0, 10'h0, 1);

        // Random traffic biased toward stack activity
        for (int i = 0; i < 800; i++) begin
            int unsigned pick;
            logic [5:0]  opc;
            pick = $urandom_range(0, 9);
            opc  = 6'($urandom_range(0, 63));
            if (pick < 3) opc[3:0] = 4'd13;
            else if (pick < 5) opc[3:0] = 4'd14;
            step(opc, 1'($urandom_range(0, 1)), PCW'($urandom),
                 ($urandom_range(0, 99) < 5));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
